// File: rtl/sdf_pkg.sv
// Shared types for the SDF delay line: FSM state encoding and phase output encoding.
package sdf_pkg;

    typedef enum logic [1:0] {
        SDF_IDLE = 2'd0,
        SDF_FILL = 2'd1,
        SDF_BFLY = 2'd2
    } sdf_state_e;

    localparam logic PHASE_FILL = 1'b0;
    localparam logic PHASE_BFLY = 1'b1;

endpackage

// File: rtl/sdf_phase_ctrl.sv
// Phase controller for one SDF stage: IDLE/FILL/BFLY FSM, beat counter within the frame,
// and the beat-level qualifiers (accept, resync, bfly_valid, frame_done, phase).
module sdf_phase_ctrl
    import sdf_pkg::*;
#(
    parameter int unsigned LANES     = 16,
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned FRAME_LEN = 512
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  valid,
    input  logic                                  frame_start,
    output logic                                  accept,
    output logic                                  resync,
    output logic                                  bfly_valid,
    output logic                                  phase,
    output logic [$clog2(FRAME_LEN/LANES)-1:0]    beat_idx,
    output logic                                  frame_done
);

    localparam int unsigned PB  = MEM_DEPTH / LANES;
    localparam int unsigned FB  = FRAME_LEN / LANES;
    localparam int unsigned BW  = $clog2(FB);
    localparam int unsigned PCW = (PB > 1) ? $clog2(PB) : 1;

    localparam logic [BW-1:0]  LastBeat = BW'(FB - 1);
    localparam logic [PCW-1:0] LastPc   = PCW'(PB - 1);

    sdf_state_e     state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;

    // frame_start is honoured from any state; other beats only count once a frame is open
    assign accept = valid && (frame_start || (state_q != SDF_IDLE));
    assign resync = valid && frame_start && (state_q != SDF_IDLE);

    // State register, frame beat counter and beat-within-phase counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SDF_IDLE;
            beat_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Next state: a frame_start beat is treated as beat 0 of FILL regardless of current state
    always_comb begin
        sdf_state_e     cur_st;
        logic [BW-1:0]  cur_beat;
        logic [PCW-1:0] cur_pc;
        state_d  = state_q;
        beat_d   = beat_q;
        pcnt_d   = pcnt_q;
        cur_st   = frame_start ? SDF_FILL : state_q;
        cur_beat = frame_start ? '0 : beat_q;
        cur_pc   = frame_start ? '0 : pcnt_q;
        if (accept) begin
            if (cur_beat == LastBeat) begin
                state_d = SDF_IDLE;
                beat_d  = '0;
                pcnt_d  = '0;
            end else begin
                beat_d = cur_beat + 1'b1;
                if (cur_pc == LastPc) begin
                    pcnt_d  = '0;
                    state_d = (cur_st == SDF_BFLY) ? SDF_FILL : SDF_BFLY;
                end else begin
                    pcnt_d  = cur_pc + 1'b1;
                    state_d = cur_st;
                end
            end
        end
    end

    // Outputs: phase from registered state, qualifiers combine it with the live valid
    always_comb begin
        phase      = (state_q == SDF_BFLY) ? PHASE_BFLY : PHASE_FILL;
        bfly_valid = valid && (state_q == SDF_BFLY);
        frame_done = valid && !frame_start && (state_q != SDF_IDLE) && (beat_q == LastBeat);
        beat_idx   = beat_q;
    end

endmodule

// File: rtl/sdf_delay_line.sv
// Delay line for one radix-2 SDF FFT stage: shifts LANES complex samples per accepted beat
// through a MEM_DEPTH-sample memory and presents the oldest LANES samples on dly_re/dly_im.
// Optional feature macro: SDF_SYNC_CHK_EN adds a sticky sync_err flag with sync_clr.
module sdf_delay_line
    import sdf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned LANES      = 16,
    parameter int unsigned MEM_DEPTH  = 128,
    parameter int unsigned FRAME_LEN  = 512
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]       din_re,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]       din_im,
    input  logic                                   valid,
    input  logic                                   frame_start,
    output logic [LANES-1:0][DATA_WIDTH-1:0]       dly_re,
    output logic [LANES-1:0][DATA_WIDTH-1:0]       dly_im,
    output logic                                   bfly_valid,
    output logic                                   phase,
    output logic [$clog2(FRAME_LEN/LANES)-1:0]     beat_idx,
    output logic                                   frame_done
`ifdef SDF_SYNC_CHK_EN
    ,
    output logic                                   sync_err,
    input  logic                                   sync_clr
`endif
);

    logic accept;
    logic resync;

    logic [DATA_WIDTH-1:0] mem_re [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_im [MEM_DEPTH];

    sdf_phase_ctrl #(
        .LANES     (LANES),
        .MEM_DEPTH (MEM_DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) u_phase_ctrl (
        .clk         (clk),
        .rstn        (rstn),
        .valid       (valid),
        .frame_start (frame_start),
        .accept      (accept),
        .resync      (resync),
        .bfly_valid  (bfly_valid),
        .phase       (phase),
        .beat_idx    (beat_idx),
        .frame_done  (frame_done)
    );

    // Shift the memory by one beat of LANES samples on each accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else if (accept) begin
            for (int i = LANES; i < MEM_DEPTH; i++) begin
                mem_re[i] <= mem_re[i-LANES];
                mem_im[i] <= mem_im[i-LANES];
            end
            for (int j = 0; j < LANES; j++) begin
                mem_re[j] <= din_re[j];
                mem_im[j] <= din_im[j];
            end
        end
    end

    // Oldest LANES samples sit at the top of the memory
    always_comb begin
        dly_re = '0;
        dly_im = '0;
        for (int k = 0; k < LANES; k++) begin
            dly_re[k] = mem_re[MEM_DEPTH-LANES+k];
            dly_im[k] = mem_im[MEM_DEPTH-LANES+k];
        end
    end

`ifdef SDF_SYNC_CHK_EN
    // Sticky resync flag; a new resync beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_err <= 1'b0;
        end else if (resync) begin
            sync_err <= 1'b1;
        end else if (sync_clr) begin
            sync_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sdf_delay_line.sv
// Self-checking bench for sdf_delay_line with default parameters (PB=8, FB=32).
// Expected delay-line outputs come from a queue scoreboard fed at stimulus time.
module tb_sdf_delay_line;

    localparam int LANES = 16;
    localparam int DW    = 9;
    localparam int PB    = 8;
    localparam int FB    = 32;

    typedef logic [LANES-1:0][DW-1:0] lane_t;

    logic       clk;
    logic       rstn;
    lane_t      din_re;
    lane_t      din_im;
    logic       valid;
    logic       frame_start;
    lane_t      dly_re;
    lane_t      dly_im;
    logic       bfly_valid;
    logic       phase;
    logic [4:0] beat_idx;
    logic       frame_done;
`ifdef SDF_SYNC_CHK_EN
    logic       sync_err;
    logic       sync_clr;
`endif

    int checks;
    int errors;

    lane_t q_re[$];
    lane_t q_im[$];

    sdf_delay_line #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .MEM_DEPTH  (128),
        .FRAME_LEN  (512)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .din_re      (din_re),
        .din_im      (din_im),
        .valid       (valid),
        .frame_start (frame_start),
        .dly_re      (dly_re),
        .dly_im      (dly_im),
        .bfly_valid  (bfly_valid),
        .phase       (phase),
        .beat_idx    (beat_idx),
        .frame_done  (frame_done)
`ifdef SDF_SYNC_CHK_EN
        ,
        .sync_err    (sync_err),
        .sync_clr    (sync_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lane_t mk_re(input int base, input int b);
        lane_t x;
        for (int l = 0; l < LANES; l++) x[l] = DW'(base + b * 16 + l);
        return x;
    endfunction

    function automatic lane_t mk_im(input int base, input int b);
        lane_t x;
        for (int l = 0; l < LANES; l++) x[l] = DW'(base * 3 + 300 - b * 16 - l);
        return x;
    endfunction

    function automatic logic exp_phase(input int b);
        return logic'((b / PB) % 2);
    endfunction

    // Memory is zero after reset, so the first PB outputs are zero beats
    task automatic sb_reset();
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < PB; i++) begin
            q_re.push_back('0);
            q_im.push_back('0);
        end
    endtask

    task automatic apply_reset();
        valid       = 1'b0;
        frame_start = 1'b0;
        rstn        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sb_reset();
    endtask

    // Present one valid beat at the falling edge; when accepted, pop the expected delayed beat
    task automatic set_beat(input lane_t re, input lane_t im, input logic fs, input logic acc);
        lane_t er;
        lane_t ei;
        @(negedge clk);
        din_re      = re;
        din_im      = im;
        valid       = 1'b1;
        frame_start = fs;
        #1;
        if (acc) begin
            er = q_re.pop_front();
            ei = q_im.pop_front();
            checks++;
            if (dly_re !== er || dly_im !== ei) begin
                errors++;
                $display("FAIL dly: got re=%h im=%h expected re=%h im=%h", dly_re, dly_im, er, ei);
            end
            q_re.push_back(re);
            q_im.push_back(im);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid       = 1'b0;
        frame_start = 1'b0;
        #1;
    endtask

    // One full frame with per-beat control checks
    task automatic run_frame(input int base);
        for (int b = 0; b < FB; b++) begin
            set_beat(mk_re(base, b), mk_im(base, b), logic'(b == 0), 1'b1);
            checks++;
            if (beat_idx !== 5'(b) || phase !== exp_phase(b) || bfly_valid !== exp_phase(b) ||
                frame_done !== logic'(b == FB - 1)) begin
                errors++;
                $display("FAIL frame beat %0d: idx=%0d ph=%b bv=%b fd=%b expected idx=%0d ph=%b bv=%b fd=%b",
                         b, beat_idx, phase, bfly_valid, frame_done, b, exp_phase(b),
                         exp_phase(b), b == FB - 1);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (beat_idx !== 5'd0 || phase !== 1'b0 || bfly_valid !== 1'b0 || frame_done !== 1'b0 ||
            dly_re !== '0 || dly_im !== '0) begin
            errors++;
            $display("FAIL reset: idx=%0d ph=%b bv=%b fd=%b expected all zero",
                     beat_idx, phase, bfly_valid, frame_done);
        end
`ifdef SDF_SYNC_CHK_EN
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset sync_err: got %b expected 0", sync_err);
        end
`endif
    endtask

    task automatic test_full_frame();
        run_frame(0);
        idle_cycle();
        checks++;
        if (beat_idx !== 5'd0 || phase !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL after frame: idx=%0d ph=%b fd=%b expected 0 0 0", beat_idx, phase, frame_done);
        end
    endtask

    task automatic test_no_frame_start();
        apply_reset();
        for (int b = 0; b < 5; b++) begin
            set_beat(mk_re(50, b), mk_im(50, b), 1'b0, 1'b0);
            checks++;
            if (beat_idx !== 5'd0 || phase !== 1'b0 || bfly_valid !== 1'b0 || frame_done !== 1'b0 ||
                dly_re !== '0 || dly_im !== '0) begin
                errors++;
                $display("FAIL idle ignore beat %0d: idx=%0d ph=%b bv=%b fd=%b expected all zero",
                         b, beat_idx, phase, bfly_valid, frame_done);
            end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        for (int b = 0; b < FB; b++) begin
            set_beat(mk_re(7, b), mk_im(7, b), logic'(b == 0), 1'b1);
            checks++;
            if (beat_idx !== 5'(b) || phase !== exp_phase(b) || bfly_valid !== exp_phase(b)) begin
                errors++;
                $display("FAIL gap beat %0d: idx=%0d ph=%b bv=%b expected idx=%0d ph=%b",
                         b, beat_idx, phase, bfly_valid, b, exp_phase(b));
            end
            if (b % 4 == 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    checks++;
                    if (bfly_valid !== 1'b0 || frame_done !== 1'b0 ||
                        beat_idx !== 5'((b + 1) % FB) || phase !== exp_phase((b + 1) % FB)) begin
                        errors++;
                        $display("FAIL gap hold after %0d: idx=%0d ph=%b bv=%b fd=%b expected idx=%0d ph=%b bv=0 fd=0",
                                 b, beat_idx, phase, bfly_valid, frame_done, (b + 1) % FB,
                                 exp_phase((b + 1) % FB));
                    end
                end
            end
        end
    endtask

    task automatic test_resync();
        apply_reset();
        for (int b = 0; b < 12; b++) set_beat(mk_re(20, b), mk_im(20, b), logic'(b == 0), 1'b1);
        set_beat(mk_re(90, 0), mk_im(90, 0), 1'b1, 1'b1);
        for (int r = 1; r < 10; r++) begin
            set_beat(mk_re(90, r), mk_im(90, r), 1'b0, 1'b1);
            checks++;
            if (beat_idx !== 5'(r) || phase !== exp_phase(r)) begin
                errors++;
                $display("FAIL resync beat %0d: idx=%0d ph=%b expected idx=%0d ph=%b",
                         r, beat_idx, phase, r, exp_phase(r));
            end
`ifdef SDF_SYNC_CHK_EN
            checks++;
            if (sync_err !== 1'b1) begin
                errors++;
                $display("FAIL sync_err set: got %b expected 1", sync_err);
            end
`endif
        end
`ifdef SDF_SYNC_CHK_EN
        @(negedge clk);
        valid    = 1'b0;
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        #1;
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_err clear: got %b expected 0", sync_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_frame(3);
        run_frame(200);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int b = 0; b < 20; b++) set_beat(mk_re(40, b), mk_im(40, b), logic'(b == 0), 1'b1);
        @(negedge clk);
        valid       = 1'b0;
        frame_start = 1'b0;
        rstn        = 1'b0;
        #1;
        checks++;
        if (beat_idx !== 5'd0 || phase !== 1'b0 || bfly_valid !== 1'b0 || frame_done !== 1'b0 ||
            dly_re !== '0 || dly_im !== '0) begin
            errors++;
            $display("FAIL mid reset: idx=%0d ph=%b bv=%b fd=%b expected all zero",
                     beat_idx, phase, bfly_valid, frame_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        sb_reset();
        run_frame(60);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rstn        = 1'b0;
        valid       = 1'b0;
        frame_start = 1'b0;
        din_re      = '0;
        din_im      = '0;
`ifdef SDF_SYNC_CHK_EN
        sync_clr    = 1'b0;
`endif
        test_reset();
        test_full_frame();
        test_no_frame_start();
        test_gaps();
        test_resync();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
